// File: rtl/core_wb_bridge.sv
// Single-outstanding bridge from a valid/ready core request port to a Wishbone
// classic master, with optional bus timeout and a one-cycle completion pulse.
module core_wb_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i,
  output logic                    busy
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(SEL_W);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic                  cyc_q, cyc_d;
  logic                  stb_q, stb_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;

  logic need_bus_s;
  logic timeout_hit_s;
  logic bus_done_s;
  logic unused_addr_s;

  // Strobe-less writes complete without touching the bus.
  assign need_bus_s    = ~req_we | (req_wstrb != {SEL_W{1'b0}});
  assign timeout_hit_s = TMO_EN & (cnt_q == TMO_LAST);
  assign bus_done_s    = wb_ack_i | wb_err_i | timeout_hit_s;
  assign unused_addr_s = ^req_addr[OFF_W-1:0];

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = need_bus_s ? ST_BUS : ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_done_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUS;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (req_valid && need_bus_s) begin
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          we_d   = req_we;
          addr_d = {req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          data_d = req_we ? req_wdata : {DATA_WIDTH{1'b0}};
          sel_d  = req_we ? req_wstrb : {SEL_W{1'b1}};
          cnt_d  = {CNT_W{1'b0}};
        end else if (req_valid) begin
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_BUS: begin
        if (bus_done_s) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          we_d        = 1'b0;
          addr_d      = {ADDR_WIDTH{1'b0}};
          data_d      = {DATA_WIDTH{1'b0}};
          sel_d       = {SEL_W{1'b0}};
          rsp_valid_d = 1'b1;
          // Error beats ack; a bare timeout (no ack) is also an error.
          rsp_err_d   = wb_err_i | ~wb_ack_i;
          if (wb_ack_i && !wb_err_i && !we_q) begin
            rsp_rdata_d = wb_data_i;
          end else begin
            rsp_rdata_d = rsp_rdata_q;
          end
        end else if (TMO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      ST_RESP: cnt_d = cnt_q;
      default: begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_core or posedge rst_core) begin
    if (rst_core) begin
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      data_q      <= {DATA_WIDTH{1'b0}};
      sel_q       <= {SEL_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= {DATA_WIDTH{1'b0}};
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_addr_o = addr_q;
  assign wb_data_o = data_q;
  assign wb_sel_o  = sel_q;

endmodule
